// File: rtl/wt_ifir.sv
// Wavelet synthesis stage: upsamples the approximation/detail pair by two,
// filters each with its synthesis taps, sums the branches and emits two samples per beat.
module wt_ifir #(
   parameter int pWIDTH  = 12,
   parameter int pORDER  = 12,
   parameter int pCWIDTH = 13,
   parameter logic signed [pCWIDTH-1:0] cLO_COEFS [0:pORDER-1] = '{
      -13'sd5,    13'sd19,   13'sd2,    -13'sd130, 13'sd112,  13'sd399,
      -13'sd532, -13'sd927,  13'sd1291,  13'sd3076, 13'sd2025, 13'sd456},
   parameter logic signed [pCWIDTH-1:0] cHI_COEFS [0:pORDER-1] = '{
      13'sd456,  -13'sd2025, 13'sd3076, -13'sd1291, -13'sd927, 13'sd532,
      13'sd399,  -13'sd112, -13'sd130,  -13'sd2,     13'sd19,  13'sd5},
   parameter int pSHIFT  = 12,
   parameter int pOWIDTH = 2*pWIDTH
) (
   input  logic                      iclk,
   input  logic                      irst,
   input  logic                      iclk_ena,
   input  logic                      iena,
   input  logic signed [pWIDTH-1:0]  idat_a,
   input  logic signed [pWIDTH-1:0]  idat_d,
   output logic                      oena,
   output logic signed [pOWIDTH-1:0] odat,
   output logic                      oerr
);

   localparam int cTAPS = pORDER / 2;
   localparam int cPW   = pWIDTH + pCWIDTH;
   localparam int cAW   = cPW + $clog2(pORDER) + 1;
   localparam int cSW   = (cAW + 1 > pOWIDTH) ? cAW + 1 : pOWIDTH;
   localparam int cRSH  = (pSHIFT > 0) ? pSHIFT - 1 : 0;
   localparam logic signed [cSW-1:0] cRND =
      (pSHIFT > 0) ? ({{(cSW-1){1'b0}}, 1'b1} << cRSH) : {cSW{1'b0}};
   localparam logic signed [pOWIDTH-1:0] cOMAX = {1'b0, {(pOWIDTH-1){1'b1}}};
   localparam logic signed [pOWIDTH-1:0] cOMIN = {1'b1, {(pOWIDTH-1){1'b0}}};

   // Full-precision coefficient x sample product.
   function automatic logic signed [cPW-1:0] mul_f(
      input logic signed [pCWIDTH-1:0] w_c,
      input logic signed [pWIDTH-1:0]  w_x);
      return cPW'(w_c) * cPW'(w_x);
   endfunction

   // Round half up by pSHIFT, then clamp into the output range.
   function automatic logic signed [pOWIDTH-1:0] scale_f(
      input logic signed [cAW-1:0] w_acc);
      logic signed [cSW-1:0] w_ext;
      logic signed [cSW-1:0] w_top;
      w_ext = cSW'(w_acc) + cRND;
      w_ext = w_ext >>> pSHIFT;
      w_top = w_ext >>> (pOWIDTH - 1);
      if (w_top == {cSW{1'b0}} || w_top == {cSW{1'b1}}) begin
         return w_ext[pOWIDTH-1:0];
      end else if (w_ext[cSW-1]) begin
         return cOMIN;
      end else begin
         return cOMAX;
      end
   endfunction

   logic signed [pWIDTH-1:0]  r_a     [0:cTAPS-1];
   logic signed [pWIDTH-1:0]  r_d     [0:cTAPS-1];
   logic signed [cPW-1:0]     r_pe_a  [0:cTAPS-1];
   logic signed [cPW-1:0]     r_po_a  [0:cTAPS-1];
   logic signed [cPW-1:0]     r_pe_d  [0:cTAPS-1];
   logic signed [cPW-1:0]     r_po_d  [0:cTAPS-1];
   logic signed [cAW-1:0]     r_sum_o;
   logic signed [pOWIDTH-1:0] r_odat;
   logic                      r_v0;
   logic                      r_v1;
   logic                      r_pend;
   logic                      r_oena;
   logic                      r_oerr;

   logic signed [cAW-1:0]     w_sum_e;
   logic signed [cAW-1:0]     w_sum_o;
   logic                      w_accept;
   logic                      w_drop;

   // r_v0 marks a beat accepted on the previous enabled cycle; a second beat there is an overrun.
   assign w_accept = iena & ~r_v0;
   assign w_drop   = iena &  r_v0;

   // Delay lines: newest sample at index 0, shifted only on an accepted beat.
   always_ff @(posedge iclk) begin
      if (irst) begin
         for (int k = 0; k < cTAPS; k++) begin
            r_a[k] <= {pWIDTH{1'b0}};
            r_d[k] <= {pWIDTH{1'b0}};
         end
      end else if (iclk_ena && w_accept) begin
         for (int k = cTAPS - 1; k > 0; k--) begin
            r_a[k] <= r_a[k-1];
            r_d[k] <= r_d[k-1];
         end
         r_a[0] <= idat_a;
         r_d[0] <= idat_d;
      end
   end

   // Product stage: even taps feed the even phase, odd taps the odd phase.
   always_ff @(posedge iclk) begin
      if (irst) begin
         for (int k = 0; k < cTAPS; k++) begin
            r_pe_a[k] <= {cPW{1'b0}};
            r_po_a[k] <= {cPW{1'b0}};
            r_pe_d[k] <= {cPW{1'b0}};
            r_po_d[k] <= {cPW{1'b0}};
         end
      end else if (iclk_ena && r_v0) begin
         for (int k = 0; k < cTAPS; k++) begin
            r_pe_a[k] <= mul_f(cLO_COEFS[2*k],   r_a[k]);
            r_po_a[k] <= mul_f(cLO_COEFS[2*k+1], r_a[k]);
            r_pe_d[k] <= mul_f(cHI_COEFS[2*k],   r_d[k]);
            r_po_d[k] <= mul_f(cHI_COEFS[2*k+1], r_d[k]);
         end
      end
   end

   // Phase sums over both branches.
   always_comb begin
      w_sum_e = {cAW{1'b0}};
      w_sum_o = {cAW{1'b0}};
      for (int k = 0; k < cTAPS; k++) begin
         w_sum_e = w_sum_e + cAW'(r_pe_a[k]) + cAW'(r_pe_d[k]);
         w_sum_o = w_sum_o + cAW'(r_po_a[k]) + cAW'(r_po_d[k]);
      end
   end

   // Control and output: even sample leaves with the sums, odd sample one enabled cycle later.
   always_ff @(posedge iclk) begin
      if (irst) begin
         r_v0    <= 1'b0;
         r_v1    <= 1'b0;
         r_pend  <= 1'b0;
         r_sum_o <= {cAW{1'b0}};
         r_odat  <= {pOWIDTH{1'b0}};
         r_oena  <= 1'b0;
         r_oerr  <= 1'b0;
      end else if (iclk_ena) begin
         r_v0   <= w_accept;
         r_v1   <= r_v0;
         r_oerr <= r_oerr | w_drop;
         // Accepts are two enabled cycles apart, so r_v1 and r_pend never coincide.
         if (r_v1) begin
            r_odat  <= scale_f(w_sum_e);
            r_sum_o <= w_sum_o;
            r_pend  <= 1'b1;
            r_oena  <= 1'b1;
         end else if (r_pend) begin
            r_odat  <= scale_f(r_sum_o);
            r_pend  <= 1'b0;
            r_oena  <= 1'b1;
         end else begin
            r_oena  <= 1'b0;
         end
      end else begin
         r_oena <= 1'b0;
      end
   end

   assign oena = r_oena;
   assign odat = r_odat;
   assign oerr = r_oerr;

endmodule

// File: tb/tb_wt_ifir.sv
// Directed bench for wt_ifir: one instance with pSHIFT=0 and one with defaults,
// driven by the same stimulus and checked against hand-computed tables.
module tb_wt_ifir;

   logic               iclk = 1'b0;
   logic               irst;
   logic               iclk_ena;
   logic               iena;
   logic signed [11:0] idat_a;
   logic signed [11:0] idat_d;
   logic               oena0, oena1, oerr0, oerr1;
   logic signed [23:0] odat0, odat1;

   wt_ifir #(.pSHIFT(0)) u_dut0 (
      .iclk(iclk), .irst(irst), .iclk_ena(iclk_ena), .iena(iena),
      .idat_a(idat_a), .idat_d(idat_d),
      .oena(oena0), .odat(odat0), .oerr(oerr0));

   wt_ifir u_dut1 (
      .iclk(iclk), .irst(irst), .iclk_ena(iclk_ena), .iena(iena),
      .idat_a(idat_a), .idat_d(idat_d),
      .oena(oena1), .odat(odat1), .oerr(oerr1));

   always #5 iclk = ~iclk;

   typedef struct {
      int a; int d;
      int e0e; int e0o;   // pSHIFT=0 instance, even/odd
      int e1e; int e1o;   // default instance, even/odd
      bit chk;
   } vec_t;

   vec_t tbl [$];
   int   q0 [$];
   int   q0_edge [$];
   int   q1 [$];
   bit   pulse_en [$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   en_edges = 0;
   bit   last_en = 1'b0;
   bit   gate = 1'b0;
   int   beat0_edge;
   int   sz0, sz1;

   // Track whether each posedge was an enabled one.
   always @(posedge iclk) begin
      last_en <= iclk_ena && !irst;
      if (iclk_ena && !irst) en_edges <= en_edges + 1;
   end

   // Collect output pulses away from the active edge.
   always @(negedge iclk) begin
      if (oena0) begin
         q0.push_back(int'(odat0));
         q0_edge.push_back(en_edges);
      end
      if (oena1) q1.push_back(int'(odat1));
      if (oena0 || oena1) pulse_en.push_back(last_en);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   function automatic void add(input int a, input int d, input int e0e, input int e0o,
                               input int e1e, input int e1o, input bit chk);
      vec_t v;
      v.a = a; v.d = d; v.e0e = e0e; v.e0o = e0o; v.e1e = e1e; v.e1o = e1o; v.chk = chk;
      tbl.push_back(v);
   endfunction

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   // One enabled cycle; in gated mode it is preceded by seven disabled clocks.
   task automatic en_cycle(input bit v, input int a, input int d);
      iena   = v;
      idat_a = 12'(a);
      idat_d = 12'(d);
      if (gate) begin
         iclk_ena = 1'b0;
         repeat (7) tick();
      end
      iclk_ena = 1'b1;
      tick();
   endtask

   task automatic beat(input int a, input int d);
      en_cycle(1'b1, a, d);
      en_cycle(1'b0, 0, 0);
   endtask

   task automatic do_reset();
      irst = 1'b1;
      tick();
      irst = 1'b0;
      q0.delete(); q0_edge.delete(); q1.delete();
   endtask

   initial begin
      irst = 1'b1; iclk_ena = 1'b0; iena = 1'b0; idat_a = 12'sd0; idat_d = 12'sd0;
      repeat (3) tick();
      check("rst_oena0", int'(oena0), 0);
      check("rst_odat0", int'(odat0), 0);
      check("rst_oerr0", int'(oerr0), 0);
      check("rst_oena1", int'(oena1), 0);
      check("rst_odat1", int'(odat1), 0);
      check("rst_oerr1", int'(oerr1), 0);
      irst = 1'b0;

      // Impulse on approximation branch
      add(1, 0,   -5,   19, 0, 0, 1);
      add(0, 0,    2, -130, 0, 0, 1);
      add(0, 0,  112,  399, 0, 0, 1);
      add(0, 0, -532, -927, 0, 0, 1);
      add(0, 0, 1291, 3076, 0, 1, 1);
      add(0, 0, 2025,  456, 0, 0, 1);
      add(0, 0,    0,    0, 0, 0, 1);
      add(0, 0,    0,    0, 0, 0, 1);
      // Impulse on detail branch
      add(0, 1,  456, -2025, 0, 0, 1);
      add(0, 0, 3076, -1291, 1, 0, 1);
      add(0, 0, -927,   532, 0, 0, 1);
      add(0, 0,  399,  -112, 0, 0, 1);
      add(0, 0, -130,    -2, 0, 0, 1);
      add(0, 0,   19,     5, 0, 0, 1);
      add(0, 0,    0,     0, 0, 0, 1);
      // DC, then saturation, then flush
      for (int i = 0; i < 5; i++) add(2047, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(2047, 0, 5921971, 5921971, 1446, 1446, 1);
      for (int i = 0; i < 5; i++) add(2047, -2048, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) add(2047, -2048, -2893, 8388607, -1, 2892, 1);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         en_cycle(1'b1, tbl[i].a, tbl[i].d);
         if (i == 0) beat0_edge = en_edges;
         en_cycle(1'b0, 0, 0);
      end
      repeat (4) en_cycle(1'b0, 0, 0);

      check("q0_count", q0.size(), 2 * tbl.size());
      check("q1_count", q1.size(), 2 * tbl.size());
      if (q0_edge.size() > 0) check("first_oena_latency", q0_edge[0] - beat0_edge, 2);
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].chk && q0.size() > 2*i+1 && q1.size() > 2*i+1) begin
            check($sformatf("vec%0d_even0", i), q0[2*i],   tbl[i].e0e);
            check($sformatf("vec%0d_odd0",  i), q0[2*i+1], tbl[i].e0o);
            check($sformatf("vec%0d_even1", i), q1[2*i],   tbl[i].e1e);
            check($sformatf("vec%0d_odd1",  i), q1[2*i+1], tbl[i].e1o);
         end
      end

      // Gated clock enable: approximation impulse again, 1 enabled clock in 8
      do_reset();
      gate = 1'b1;
      for (int i = 0; i < 8; i++) beat(tbl[i].a, tbl[i].d);
      repeat (4) en_cycle(1'b0, 0, 0);
      gate = 1'b0;
      check("gated_q0_count", q0.size(), 16);
      for (int i = 0; i < 8; i++) begin
         if (q0.size() > 2*i+1) begin
            check($sformatf("gated%0d_even", i), q0[2*i],   tbl[i].e0e);
            check($sformatf("gated%0d_odd",  i), q0[2*i+1], tbl[i].e0o);
         end
      end

      // Overrun: second beat on the next enabled cycle is dropped
      do_reset();
      check("ovr_oerr_before", int'(oerr0), 0);
      en_cycle(1'b1, 1, 0);
      en_cycle(1'b1, 100, 0);
      check("ovr_oerr_set0", int'(oerr0), 1);
      check("ovr_oerr_set1", int'(oerr1), 1);
      repeat (6) en_cycle(1'b0, 0, 0);
      check("ovr_pulses0", q0.size(), 2);
      check("ovr_pulses1", q1.size(), 2);
      if (q0.size() >= 2) begin
         check("ovr_even", q0[0], -5);
         check("ovr_odd",  q0[1], 19);
      end
      // Dropped cycle does not restart the window: accept, drop, accept
      en_cycle(1'b1, 0, 0);
      en_cycle(1'b1, 0, 0);
      en_cycle(1'b1, 0, 0);
      repeat (6) en_cycle(1'b0, 0, 0);
      check("window_pulses", q0.size(), 6);
      if (q0.size() >= 6) begin
         check("window_e1", q0[2], 2);
         check("window_o1", q0[3], -130);
         check("window_e2", q0[4], 112);
         check("window_o2", q0[5], 399);
      end
      check("ovr_oerr_sticky", int'(oerr0), 1);

      // Reset between the even and odd output
      en_cycle(1'b1, 1, 0);
      en_cycle(1'b0, 0, 0);
      en_cycle(1'b0, 0, 0);
      check("mid_even_oena", int'(oena0), 1);
      check("mid_even_odat", int'(odat0), -537);
      irst = 1'b1;
      tick();
      irst = 1'b0;
      check("mid_rst_oena", int'(oena0), 0);
      check("mid_rst_odat", int'(odat0), 0);
      check("mid_rst_oerr", int'(oerr0), 0);
      check("mid_rst_oena1", int'(oena1), 0);
      sz0 = q0.size();
      sz1 = q1.size();
      repeat (4) en_cycle(1'b0, 0, 0);
      check("mid_no_odd0", q0.size(), sz0);
      check("mid_no_odd1", q1.size(), sz1);

      for (int i = 0; i < pulse_en.size(); i++)
         check($sformatf("pulse%0d_on_enabled_edge", i), int'(pulse_en[i]), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
